// File: rtl/wbcon_arbiter_pkg.sv
// Shared types and width helpers for the wbcon Wishbone arbiter family.
package wbcon_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_e;

    localparam int WB_AW_DEF = 24;
    localparam int WB_DW_DEF = 32;

    // Watchdog counter width; a disabled watchdog still keeps a 1-bit register.
    function automatic int cnt_width(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/wbcon_rr_pick.sv
// Combinational round-robin picker: first asserted request after 'last', wrapping.
module wbcon_rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Scan from farthest to nearest so the requester closest after 'last' wins.
    always_comb begin
        int k;
        valid = 1'b0;
        idx   = last;
        k     = 0;
        for (int i = N; i >= 1; i--) begin
            k = int'(last) + i;
            if (k >= N) k = k - N;
            if (req[k]) begin
                valid = 1'b1;
                idx   = IW'(k);
            end
        end
    end

endmodule

// File: rtl/wbcon_arbiter.sv
// N-master to 1-slave pipelined Wishbone arbiter: round-robin grant held for the
// whole CYC, with a bus watchdog that aborts hung cycles with ERR.
module wbcon_arbiter
    import wbcon_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int WB_ADDR_WIDTH  = WB_AW_DEF,
    parameter int WB_DATA_WIDTH  = WB_DW_DEF,
    parameter int WB_SEL_WIDTH   = (WB_DATA_WIDTH + 7) / 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic [NUM_MASTERS-1:0]               i_m_cyc,
    input  logic [NUM_MASTERS-1:0]               i_m_stb,
    input  logic [NUM_MASTERS-1:0]               i_m_we,
    input  logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0] i_m_adr,
    input  logic [NUM_MASTERS*WB_DATA_WIDTH-1:0] i_m_dat,
    input  logic [NUM_MASTERS*WB_SEL_WIDTH-1:0]  i_m_sel,
    output logic [NUM_MASTERS-1:0]               o_m_stall,
    output logic [NUM_MASTERS-1:0]               o_m_ack,
    output logic [NUM_MASTERS-1:0]               o_m_err,
    output logic [NUM_MASTERS-1:0]               o_m_rty,
    output logic [WB_DATA_WIDTH-1:0]             o_m_dat,
    output logic                                 o_s_cyc,
    output logic                                 o_s_stb,
    output logic                                 o_s_we,
    output logic [WB_ADDR_WIDTH-1:0]             o_s_adr,
    output logic [WB_DATA_WIDTH-1:0]             o_s_dat,
    output logic [WB_SEL_WIDTH-1:0]              o_s_sel,
    input  logic                                 i_s_stall,
    input  logic                                 i_s_ack,
    input  logic                                 i_s_err,
    input  logic                                 i_s_rty,
    input  logic [WB_DATA_WIDTH-1:0]             i_s_dat,
    output logic [NUM_MASTERS-1:0]               o_grant,
    output logic                                 o_timeout
);

    localparam int IW    = $clog2(NUM_MASTERS);
    localparam int CW    = cnt_width(TIMEOUT_CYCLES);
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
    // Abort fires on the cycle the counter would step onto the limit.
    localparam logic [CW-1:0] CNT_LAST = WD_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

    arb_state_e    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] last_q,  last_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic          own_cyc;
    logic          s_resp;

    wbcon_rr_pick #(.N(NUM_MASTERS), .IW(IW)) u_pick (
        .req   (i_m_cyc),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign own_cyc = i_m_cyc[owner_q];
    assign s_resp  = i_s_ack | i_s_err | i_s_rty;

    // Address/data/sel/we always follow the owner; only CYC/STB qualify them.
    assign o_s_we  = i_m_we[owner_q];
    assign o_s_adr = i_m_adr[int'(owner_q)*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
    assign o_s_dat = i_m_dat[int'(owner_q)*WB_DATA_WIDTH +: WB_DATA_WIDTH];
    assign o_s_sel = i_m_sel[int'(owner_q)*WB_SEL_WIDTH +: WB_SEL_WIDTH];
    assign o_m_dat = i_s_dat;

    always_comb begin
        o_grant = '0;
        if (state_q != ST_IDLE) o_grant[owner_q] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= IW'(NUM_MASTERS - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        o_s_cyc   = 1'b0;
        o_s_stb   = 1'b0;
        o_m_stall = '1;
        o_m_ack   = '0;
        o_m_err   = '0;
        o_m_rty   = '0;
        o_timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pick_valid) begin
                    state_d = ST_OWNED;
                    owner_d = pick_idx;
                end
            end
            ST_OWNED: begin
                o_s_cyc            = own_cyc;
                o_s_stb            = own_cyc & i_m_stb[owner_q];
                o_m_stall[owner_q] = i_s_stall;
                // Responses arriving after the owner dropped CYC are discarded.
                if (own_cyc) begin
                    o_m_ack[owner_q] = i_s_ack;
                    o_m_err[owner_q] = i_s_err;
                    o_m_rty[owner_q] = i_s_rty;
                end
                if (!own_cyc) begin
                    state_d = ST_IDLE;
                    last_d  = owner_q;
                    cnt_d   = '0;
                end else if ((o_s_stb && !i_s_stall) || s_resp) begin
                    cnt_d = '0;
                end else if (WD_EN) begin
                    if (cnt_q == CNT_LAST) begin
                        o_m_err[owner_q] = 1'b1;
                        o_timeout        = 1'b1;
                        state_d          = ST_ABORT;
                    end
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_ABORT: begin
                if (!own_cyc) begin
                    state_d = ST_IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
